operand_fetch: RTL and testbench

Register-read stage of the core; it is the initiator that drives the regfile read ports (rs1/rs2 en/addr) and sources the writeback port (dest_*).
- Accepts decoded instructions over a valid/ready handshake.
- Tracks in-flight destination registers in a scoreboard and stalls on RAW/WAW hazards.
- Bypasses same-cycle writeback data.
- Presents registered operands to execute.

---
 rtl/core_pkg.sv | 14 +
 rtl/operand_fetch_if.sv | 56 +++++
 rtl/operand_fetch_reg_scoreboard.sv | 46 ++++
 rtl/operand_fetch.sv | 111 +++++++++++
 tb/tb_operand_fetch.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// core_pkg: widths, address/data types and constants that the core stages share.
//   WIDTH      data width (XLEN)
//   REG_COUNT  number of architectural registers (x0 reads as zero)
//   ADDR_WIDTH register address width
package core_pkg;
  localparam int WIDTH      = 32;
  localparam int REG_COUNT  = 32;
  localparam int ADDR_WIDTH = $clog2(REG_COUNT);

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [WIDTH-1:0]      word_t;

  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: every bus the register-read stage touches, bundled together.
//   in_*    decoded instruction from decode (valid/ready)
//   rf_*    regfile read ports 1/2 and the writeback port (dest)
//   wb_*    writeback from execute/memory
//   flush   kills the instruction held in the output register
//   out_*   operands to execute (valid/ready)
// Modports: slave = the operand_fetch stage, master = the surrounding pipeline.
interface operand_fetch_if #(
  parameter int WIDTH      = core_pkg::WIDTH,
  parameter int ADDR_WIDTH = core_pkg::ADDR_WIDTH
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_rs1_addr;
  logic [ADDR_WIDTH-1:0] in_rs2_addr;
  logic [ADDR_WIDTH-1:0] in_rd_addr;
  logic                  in_rd_wr;

  logic                  rf_rs1_en;
  logic [ADDR_WIDTH-1:0] rf_rs1_addr;
  logic [WIDTH-1:0]      rf_rs1_data;
  logic                  rf_rs2_en;
  logic [ADDR_WIDTH-1:0] rf_rs2_addr;
  logic [WIDTH-1:0]      rf_rs2_data;

  logic                  wb_en;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [WIDTH-1:0]      wb_data;
  logic                  rf_dest_en;
  logic [ADDR_WIDTH-1:0] rf_dest_addr;
  logic [WIDTH-1:0]      rf_dest_data;

  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_rs1_val;
  logic [WIDTH-1:0]      out_rs2_val;
  logic [ADDR_WIDTH-1:0] out_rd_addr;
  logic                  out_rd_wr;

  modport slave (
    input  in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rd_wr,
    input  rf_rs1_data, rf_rs2_data, wb_en, wb_addr, wb_data, flush, out_ready,
    output in_ready, rf_rs1_en, rf_rs1_addr, rf_rs2_en, rf_rs2_addr,
    output rf_dest_en, rf_dest_addr, rf_dest_data,
    output out_valid, out_rs1_val, out_rs2_val, out_rd_addr, out_rd_wr
  );

  modport master (
    output in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rd_wr,
    output rf_rs1_data, rf_rs2_data, wb_en, wb_addr, wb_data, flush, out_ready,
    input  in_ready, rf_rs1_en, rf_rs1_addr, rf_rs2_en, rf_rs2_addr,
    input  rf_dest_en, rf_dest_addr, rf_dest_data,
    input  out_valid, out_rs1_val, out_rs2_val, out_rd_addr, out_rd_wr
  );
endinterface

// File: rtl/operand_fetch_reg_scoreboard.sv
// reg_scoreboard: one pending bit per architectural register.
//   clk, rst_n           clock / async active-low reset (clears every bit)
//   set_en/set_addr      new writer accepted
//   clr_a_en/clr_a_addr  writeback retires a writer
//   clr_b_en/clr_b_addr  flushed writer
//   q_addr/q_hit         NUM_Q combinational lookups (x0 never hits)
// A set and a clear of the same bit in one cycle leave it set: the clear
// belongs to the old writer, the set to the new one.
module reg_scoreboard
  import core_pkg::*;
#(
  parameter int REG_COUNT  = core_pkg::REG_COUNT,
  parameter int ADDR_WIDTH = core_pkg::ADDR_WIDTH,
  parameter int NUM_Q      = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             set_en,
  input  logic [ADDR_WIDTH-1:0]            set_addr,
  input  logic                             clr_a_en,
  input  logic [ADDR_WIDTH-1:0]            clr_a_addr,
  input  logic                             clr_b_en,
  input  logic [ADDR_WIDTH-1:0]            clr_b_addr,
  input  logic [NUM_Q-1:0][ADDR_WIDTH-1:0] q_addr,
  output logic [NUM_Q-1:0]                 q_hit
);
  logic [REG_COUNT-1:0] pending;
  logic [REG_COUNT-1:0] pending_d;

  always_comb begin
    pending_d = pending;
    if (clr_a_en) pending_d[clr_a_addr] = 1'b0;
    if (clr_b_en) pending_d[clr_b_addr] = 1'b0;
    if (set_en)   pending_d[set_addr]   = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_d;
  end

  for (genvar i = 0; i < NUM_Q; i++) begin : g_q
    assign q_hit[i] = pending[q_addr[i]] && (q_addr[i] != REG_ZERO);
  end
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage. Reads rs1/rs2 from the regfile, stalls
// on RAW/WAW hazards against in-flight writers, and registers the operands
// for execute with a one-cycle latency.
//   clk, rst_n  clock / async active-low reset
//   bus         operand_fetch_if.slave (decode in, regfile ports, writeback,
//               flush, execute out)
// Build option OPFETCH_BYPASS_EN: when defined, a writeback in the same cycle
// both resolves the hazard and forwards wb_data into the operand; when
// undefined, the stage waits until the value is visible in the regfile.
module operand_fetch
  import core_pkg::*;
#(
  parameter int WIDTH      = core_pkg::WIDTH,
  parameter int REG_COUNT  = core_pkg::REG_COUNT,
  parameter int ADDR_WIDTH = core_pkg::ADDR_WIDTH
) (
  input logic            clk,
  input logic            rst_n,
  operand_fetch_if.slave bus
);
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [WIDTH-1:0]      data_t;
  typedef struct packed {
    data_t rs1_val;
    data_t rs2_val;
    addr_t rd_addr;
    logic  rd_wr;
  } opnd_t;

  // lookup slots: 0 = rs1, 1 = rs2, 2 = rd
  addr_t [2:0] q_addr;
  logic  [2:0] sb_hit;
  logic  [2:0] pend;
  logic        hazard;
  logic        accept;
  logic        out_valid_q;
  opnd_t       out_q;
  opnd_t       out_d;

  assign q_addr = {bus.in_rd_addr, bus.in_rs2_addr, bus.in_rs1_addr};

`ifdef OPFETCH_BYPASS_EN
  logic [2:0] wb_hit;
  for (genvar i = 0; i < 3; i++) begin : g_pend
    assign wb_hit[i] = bus.wb_en && (bus.wb_addr == q_addr[i]);
    assign pend[i]   = sb_hit[i] && !wb_hit[i];
  end
`else
  assign pend = sb_hit;
`endif

  assign hazard = bus.in_valid && (pend[0] || pend[1] || (bus.in_rd_wr && pend[2]));
  // flush blocks accept so a killed slot is never refilled in the same cycle
  assign bus.in_ready = !hazard && (!out_valid_q || bus.out_ready) && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    out_d         = '0;
    out_d.rs1_val = (bus.in_rs1_addr == REG_ZERO) ? '0 : bus.rf_rs1_data;
    out_d.rs2_val = (bus.in_rs2_addr == REG_ZERO) ? '0 : bus.rf_rs2_data;
`ifdef OPFETCH_BYPASS_EN
    if (bus.in_rs1_addr != REG_ZERO && wb_hit[0]) out_d.rs1_val = bus.wb_data;
    if (bus.in_rs2_addr != REG_ZERO && wb_hit[1]) out_d.rs2_val = bus.wb_data;
`endif
    out_d.rd_addr = bus.in_rd_addr;
    out_d.rd_wr   = bus.in_rd_wr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_q       <= out_d;
    end else if (bus.flush || bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  reg_scoreboard #(
    .REG_COUNT  (REG_COUNT),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_Q      (3)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (accept && bus.in_rd_wr),
    .set_addr   (bus.in_rd_addr),
    .clr_a_en   (bus.wb_en),
    .clr_a_addr (bus.wb_addr),
    .clr_b_en   (bus.flush && out_valid_q && out_q.rd_wr),
    .clr_b_addr (out_q.rd_addr),
    .q_addr     (q_addr),
    .q_hit      (sb_hit)
  );

  assign bus.rf_rs1_en    = bus.in_valid;
  assign bus.rf_rs1_addr  = bus.in_rs1_addr;
  assign bus.rf_rs2_en    = bus.in_valid;
  assign bus.rf_rs2_addr  = bus.in_rs2_addr;
  assign bus.rf_dest_en   = bus.wb_en && (bus.wb_addr != REG_ZERO);
  assign bus.rf_dest_addr = bus.wb_addr;
  assign bus.rf_dest_data = bus.wb_data;

  assign bus.out_valid   = out_valid_q;
  assign bus.out_rs1_val = out_q.rs1_val;
  assign bus.out_rs2_val = out_q.rs2_val;
  assign bus.out_rd_addr = out_q.rd_addr;
  assign bus.out_rd_wr   = out_q.rd_wr;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed bench for operand_fetch with a behavioural
// regfile, a reference model compared every negedge, and literal spot checks.
module tb_operand_fetch;
  import core_pkg::*;

`ifdef OPFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  operand_fetch_if bus ();
  operand_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t init_val(input int i);
    return 32'h1000_0000 + i;
  endfunction

  // regfile: combinational read, write visible the cycle after dest_en
  word_t env_rf [REG_COUNT];
  logic  env_ready = 1'b0;
  assign bus.rf_rs1_data = env_rf[bus.rf_rs1_addr];
  assign bus.rf_rs2_data = env_rf[bus.rf_rs2_addr];
  always @(posedge clk) begin
    if (!env_ready) begin
      for (int i = 0; i < REG_COUNT; i++) env_rf[i] <= init_val(i);
      env_ready <= 1'b1;
    end else if (bus.rf_dest_en) begin
      env_rf[bus.rf_dest_addr] <= bus.rf_dest_data;
    end
  end

  // ---------------- reference model ----------------
  logic [REG_COUNT-1:0] mpend;
  word_t     mrf [REG_COUNT];
  bit        minit = 1'b0;
  logic      mov, mwr;
  word_t     m1, m2;
  reg_addr_t mrd;

  function automatic bit pend_of(input reg_addr_t r);
    return mpend[r] && (r != 0) && !(BYP && bus.wb_en && bus.wb_addr == r);
  endfunction

  function automatic word_t opv(input reg_addr_t r);
    if (r == 0) return '0;
    if (BYP && bus.wb_en && bus.wb_addr == r) return bus.wb_data;
    return mrf[r];
  endfunction

  initial forever @(negedge clk) begin : model
    logic haz, rdy, acc;
    logic [REG_COUNT-1:0] np;
    if (!minit) begin
      for (int i = 0; i < REG_COUNT; i++) mrf[i] = init_val(i);
      minit = 1'b1;
    end
    if (!rst_n) begin
      mpend = '0; mov = 1'b0; mwr = 1'b0; m1 = '0; m2 = '0; mrd = '0;
      chk("m_rst_out_valid", bus.out_valid, 0);
      chk("m_rst_rs1", bus.out_rs1_val, 0);
      chk("m_rst_rs2", bus.out_rs2_val, 0);
      chk("m_rst_rd", {bus.out_rd_wr, bus.out_rd_addr}, 0);
      chk("m_rst_pending", dut.u_sb.pending, 0);
    end else begin
      haz = bus.in_valid && (pend_of(bus.in_rs1_addr) || pend_of(bus.in_rs2_addr) ||
                             (bus.in_rd_wr && pend_of(bus.in_rd_addr)));
      rdy = !haz && (!mov || bus.out_ready) && !bus.flush;
      acc = bus.in_valid && rdy;
      chk("m_in_ready", bus.in_ready, rdy);
      chk("m_rf_en", {bus.rf_rs1_en, bus.rf_rs2_en}, {bus.in_valid, bus.in_valid});
      chk("m_rf_addr", {bus.rf_rs1_addr, bus.rf_rs2_addr}, {bus.in_rs1_addr, bus.in_rs2_addr});
      chk("m_dest_en", bus.rf_dest_en, bus.wb_en && bus.wb_addr != 0);
      chk("m_dest", {bus.rf_dest_addr, bus.rf_dest_data}, {bus.wb_addr, bus.wb_data});
      chk("m_out_valid", bus.out_valid, mov);
      if (mov) begin
        chk("m_out_rs1", bus.out_rs1_val, m1);
        chk("m_out_rs2", bus.out_rs2_val, m2);
        chk("m_out_rd", {bus.out_rd_wr, bus.out_rd_addr}, {mwr, mrd});
      end
      chk("m_pending", dut.u_sb.pending, mpend);
      np = mpend;
      if (bus.wb_en && bus.wb_addr != 0) np[bus.wb_addr] = 1'b0;
      if (bus.flush && mov && mwr && mrd != 0) np[mrd] = 1'b0;
      if (acc && bus.in_rd_wr && bus.in_rd_addr != 0) np[bus.in_rd_addr] = 1'b1;
      if (acc) begin
        m1 = opv(bus.in_rs1_addr); m2 = opv(bus.in_rs2_addr);
        mrd = bus.in_rd_addr; mwr = bus.in_rd_wr; mov = 1'b1;
      end else if (bus.flush || (mov && bus.out_ready)) begin
        mov = 1'b0;
      end
      mpend = np;
      if (bus.wb_en && bus.wb_addr != 0) mrf[bus.wb_addr] = bus.wb_data;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();   @(posedge clk); #1; endtask
  task automatic settle(); #1; endtask
  task automatic issue(input reg_addr_t a1, input reg_addr_t a2, input reg_addr_t rd, input logic wr);
    bus.in_valid = 1'b1; bus.in_rs1_addr = a1; bus.in_rs2_addr = a2;
    bus.in_rd_addr = rd; bus.in_rd_wr = wr;
  endtask
  task automatic idle(); bus.in_valid = 1'b0; endtask
  task automatic wb(input reg_addr_t a, input word_t d);
    bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
  endtask
  task automatic nowb(); bus.wb_en = 1'b0; endtask

  // writeback that releases a stalled reader already on the input
  task automatic release_wb(input string tag, input reg_addr_t a, input word_t d,
                            input word_t e1, input word_t e2);
    wb(a, d); settle();
`ifdef OPFETCH_BYPASS_EN
    chk({tag, "_byp_ready"}, bus.in_ready, 1);
    step(); nowb(); idle(); settle();
`else
    chk({tag, "_wait"}, bus.in_ready, 0);
    step(); nowb(); settle();
    chk({tag, "_ready"}, bus.in_ready, 1);
    step(); idle(); settle();
`endif
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk({tag, "_rs1"}, bus.out_rs1_val, e1);
    chk({tag, "_rs2"}, bus.out_rs2_val, e2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_rs1_addr = '0; bus.in_rs2_addr = '0;
    bus.in_rd_addr = '0; bus.in_rd_wr = 1'b0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (2) step();
    rst_n = 1'b1; settle();
    chk("idle_out_valid", bus.out_valid, 0);
    chk("idle_in_ready", bus.in_ready, 1);

    // basic issue and retire
    step(); issue(1, 2, 3, 1); settle();
    chk("basic_ready", bus.in_ready, 1);
    step(); idle(); settle();
    chk("basic_valid", bus.out_valid, 1);
    chk("basic_rs1", bus.out_rs1_val, 32'h1000_0001);
    chk("basic_rs2", bus.out_rs2_val, 32'h1000_0002);
    chk("basic_rd", bus.out_rd_addr, 3);
    step(); wb(3, 32'hAAAA_0003); settle();
    chk("wb_dest_en", bus.rf_dest_en, 1);
    step(); nowb();

    // reset in the middle of a stall
    issue(0, 0, 5, 1); step();
    issue(5, 0, 6, 0); settle();
    chk("stall_pre_rst", bus.in_ready, 0);
    step(); rst_n = 1'b0; settle();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_pending", dut.u_sb.pending, 0);
    idle(); step(); rst_n = 1'b1;

    // RAW stall on x5
    step(); issue(0, 0, 5, 1); step();
    issue(5, 1, 6, 0); settle();
    chk("raw_stall0", bus.in_ready, 0);
    step(); settle();
    chk("raw_stall1", bus.in_ready, 0);
    release_wb("raw", 5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1000_0001);

    // x0 is never pending and always reads zero
    step(); issue(0, 0, 0, 1); settle();
    chk("x0w_ready", bus.in_ready, 1);
    step(); issue(0, 0, 1, 0); settle();
    chk("x0_no_stall", bus.in_ready, 1);
    step(); idle(); wb(0, 32'h0000_1234); settle();
    chk("x0_rs1", bus.out_rs1_val, 0);
    chk("x0_rs2", bus.out_rs2_val, 0);
    chk("x0_dest_en", bus.rf_dest_en, 0);
    step(); nowb();

    // backpressure: output held for three cycles
    issue(1, 2, 8, 0); step();
    bus.out_ready = 1'b0; issue(3, 4, 10, 0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_ready", bus.in_ready, 0);
      chk("bp_hold_rs1", bus.out_rs1_val, 32'h1000_0001);
      chk("bp_hold_valid", bus.out_valid, 1);
      step();
    end
    bus.out_ready = 1'b1; settle();
    chk("bp_release_ready", bus.in_ready, 1);
    step(); idle(); settle();
    chk("bp_next_rs1", bus.out_rs1_val, 32'hAAAA_0003);
    chk("bp_next_rs2", bus.out_rs2_val, 32'h1000_0004);
    chk("bp_next_rd", bus.out_rd_addr, 10);

    // flush of a held writer to x7
    step(); issue(1, 2, 7, 1); step();
    idle(); bus.out_ready = 1'b0; bus.flush = 1'b1; settle();
    chk("flush_in_ready", bus.in_ready, 0);
    step(); bus.flush = 1'b0; bus.out_ready = 1'b1; settle();
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_pend7", dut.u_sb.pending[7], 0);
    issue(7, 0, 12, 0); settle();
    chk("flush_reader_ready", bus.in_ready, 1);
    step(); idle(); settle();
    chk("flush_reader_rs1", bus.out_rs1_val, 32'h1000_0007);

    // flush outranks out_ready
    step(); issue(0, 0, 11, 1); step();
    issue(2, 0, 13, 0); bus.flush = 1'b1; settle();
    chk("flush_rank_ready", bus.in_ready, 0);
    step(); bus.flush = 1'b0; settle();
    chk("flush_rank_valid", bus.out_valid, 0);
    chk("flush_rank_pend11", dut.u_sb.pending[11], 0);
    chk("flush_rank_after", bus.in_ready, 1);
    step(); idle(); settle();
    chk("flush_rank_rs1", bus.out_rs1_val, 32'h1000_0002);

    // set wins over a same-cycle clear of x9
    step(); issue(0, 0, 9, 1); wb(9, 32'h0000_0099); settle();
    chk("soc_ready", bus.in_ready, 1);
    step(); nowb(); issue(9, 9, 14, 0); settle();
    chk("soc_pend9", dut.u_sb.pending[9], 1);
    chk("soc_stall0", bus.in_ready, 0);
    step(); settle();
    chk("soc_stall1", bus.in_ready, 0);
    release_wb("soc", 9, 32'h9999_0009, 32'h9999_0009, 32'h9999_0009);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
